// File: rtl/slurmboy_pkg.sv
// Shared definitions for the GPI AXI4-lite controller: register offsets
// (address bits [3:2]) and the write/read channel FSM state encodings.
package slurmboy_pkg;

  localparam logic [1:0] GPI_REG_STATE   = 2'd0;
  localparam logic [1:0] GPI_REG_PRESS   = 2'd1;
  localparam logic [1:0] GPI_REG_RELEASE = 2'd2;
  localparam logic [1:0] GPI_REG_IRQ_EN  = 2'd3;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/gpi_debounce.sv
// One button: polarity stage, 2-flop synchroniser, stability counter and
// debounced level. press_o/release_o pulse for one cycle, combinationally,
// on the cycle whose edge updates the debounced level.
module gpi_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          pin_pol;
  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          settle;

  // Pressed is always 1 internally, whatever the pin polarity.
  assign pin_pol = ACTIVE_LOW ? ~pin_i : pin_i;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], pin_pol};
  end

  // The new level has been seen for the full window on this cycle.
  assign settle = (sync_q[1] != level_q) && (cnt_q == CNT_LAST);

  // Count consecutive disagreeing cycles; any agreement restarts the window.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (settle) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and debounced level registers.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = settle & sync_q[1];
  assign release_o = settle & ~sync_q[1];

endmodule

// File: rtl/gpi_axil_ctrl.sv
// AXI4-lite GPI peripheral: debounced button levels, sticky press/release
// events (write-one-to-clear), an interrupt mask and a registered level irq.
module gpi_axil_ctrl
  import slurmboy_pkg::*;
#(
  parameter int NUM_BUTTONS     = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RSTb,
  input  logic [NUM_BUTTONS-1:0] gpi,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_awaddr,
  input  logic [2:0]             s_axi_awprot,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  input  logic [31:0]            s_axi_araddr,
  input  logic [2:0]             s_axi_arprot,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [31:0]            s_axi_rdata,
  output logic                   irq_out
);

  localparam int NB = NUM_BUTTONS;

  logic [NB-1:0] state_w, press_evt, release_evt;
  logic [NB-1:0] press_q, press_d, release_q, release_d, irq_en_q, irq_en_d;
  logic [NB-1:0] wbits;
  wr_state_e     w_state_q, w_state_d;
  rd_state_e     r_state_q, r_state_d;
  logic          wr_hs, rd_hs, wr_en, irq_q;
  logic [31:0]   rdata_q, rd_word;
  logic          unused_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      gpi_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_db (
        .CLK      (CLK),
        .RSTb     (RSTb),
        .pin_i    (gpi[gi]),
        .level_o  (state_w[gi]),
        .press_o  (press_evt[gi]),
        .release_o(release_evt[gi])
      );
    end
  endgenerate

  // Write channel: accept AW and W together only, then hold the response.
  always_comb begin
    w_state_d    = w_state_q;
    wr_hs        = 1'b0;
    s_axi_bvalid = 1'b0;
    case (w_state_q)
      W_IDLE: if (s_axi_awvalid && s_axi_wvalid) begin
        wr_hs     = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;

  // Read channel: address accepted in idle, data held until taken.
  always_comb begin
    r_state_d     = r_state_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    rd_hs         = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          rd_hs     = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // FSM state registers.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  assign wbits = s_axi_wdata[NB-1:0];
  assign wr_en = wr_hs & s_axi_wstrb[0];

  // Register file next state; a new event overrides a same-cycle clear.
  always_comb begin
    press_d   = press_q | press_evt;
    release_d = release_q | release_evt;
    irq_en_d  = irq_en_q;
    if (wr_en) begin
      case (s_axi_awaddr[3:2])
        GPI_REG_PRESS:   press_d   = (press_q & ~wbits) | press_evt;
        GPI_REG_RELEASE: release_d = (release_q & ~wbits) | release_evt;
        GPI_REG_IRQ_EN:  irq_en_d  = wbits;
        default:         ;
      endcase
    end
  end

  // Read mux over the current (pre-update) register values.
  always_comb begin
    rd_word = '0;
    case (s_axi_araddr[3:2])
      GPI_REG_STATE:   rd_word[NB-1:0] = state_w;
      GPI_REG_PRESS:   rd_word[NB-1:0] = press_q;
      GPI_REG_RELEASE: rd_word[NB-1:0] = release_q;
      GPI_REG_IRQ_EN:  rd_word[NB-1:0] = irq_en_q;
      default:         rd_word = '0;
    endcase
  end

  // Registers, captured read data and the registered interrupt.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      press_q   <= '0;
      release_q <= '0;
      irq_en_q  <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= |(press_q & irq_en_q);
      if (rd_hs) rdata_q <= rd_word;
    end
  end

  assign s_axi_rdata = rdata_q;
  assign irq_out     = irq_q;

  // Address, protection and strobe bits the block does not decode.
  assign unused_bits = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0],
                         s_axi_araddr[31:4], s_axi_araddr[1:0],
                         s_axi_awprot, s_axi_arprot,
                         s_axi_wstrb[3:1], s_axi_wdata[31:NB]};

endmodule

// File: tb/tb_gpi_axil_ctrl.sv
// Bench for gpi_axil_ctrl with DEBOUNCE_CYCLES = 4, active-low pins.
module tb_gpi_axil_ctrl;

  localparam int NB = 6;
  localparam int DB = 4;
  localparam int HL = DB + 2;

  logic          CLK = 1'b0;
  logic          RSTb = 1'b0;
  logic [NB-1:0] gpi = '1;
  logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0]   awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid, irq_out;
  logic [31:0]   rdata;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [NB-1:0] hist [0:HL-1];
  logic [NB-1:0] m_state, m_press, m_rel, m_irqen;
  logic          m_irq, m_wpend, m_rpend, wr_fire, rd_fire;
  logic [31:0]   m_rdata;

  gpi_axil_ctrl #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1'b1)) dut (
    .CLK(CLK), .RSTb(RSTb), .gpi(gpi),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_awprot(3'b000),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_arprot(3'b000),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
    .irq_out(irq_out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic m_reset();
    for (int a = 0; a < HL; a++) hist[a] = '0;
    m_state = '0; m_press = '0; m_rel = '0; m_irqen = '0;
    m_irq = 0; m_wpend = 0; m_rpend = 0; m_rdata = '0;
    wr_fire = 0; rd_fire = 0;
  endtask

  function automatic logic [31:0] m_reg(input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    case (a[3:2])
      2'd0: v[NB-1:0] = m_state;
      2'd1: v[NB-1:0] = m_press;
      2'd2: v[NB-1:0] = m_rel;
      default: v[NB-1:0] = m_irqen;
    endcase
    return v;
  endfunction

  // Advance one clock: update the model from the inputs present before the
  // edge, then wait for the edge and settle 1 time unit past it.
  // A level is accepted once the synchronised value (pin seen 2 edges ago)
  // has differed from the debounced level for the last DB edges.
  task automatic tick();
    logic [NB-1:0] pev, rev, wmask;
    logic wr, rd, nirq;
    bit diff;
    if (RSTb) begin
      for (int a = HL - 1; a > 0; a--) hist[a] = hist[a-1];
      hist[0] = ~gpi;
      pev = '0; rev = '0;
      for (int b = 0; b < NB; b++) begin
        diff = 1;
        for (int a = 2; a <= DB + 1; a++) if (hist[a][b] == m_state[b]) diff = 0;
        if (diff) begin
          if (m_state[b]) rev[b] = 1'b1;
          else            pev[b] = 1'b1;
        end
      end
      wr = !m_wpend && awvalid && wvalid;
      rd = !m_rpend && arvalid;
      if (rd) m_rdata = m_reg(araddr);
      nirq  = |(m_press & m_irqen);
      wmask = (wr && wstrb[0]) ? wdata[NB-1:0] : '0;
      if (awaddr[3:2] == 2'd1) m_press = (m_press & ~wmask) | pev;
      else                     m_press = m_press | pev;
      if (awaddr[3:2] == 2'd2) m_rel = (m_rel & ~wmask) | rev;
      else                     m_rel = m_rel | rev;
      if (awaddr[3:2] == 2'd3 && wr && wstrb[0]) m_irqen = wdata[NB-1:0];
      m_state = m_state ^ (pev | rev);
      m_irq = nirq;
      if (wr) m_wpend = 1; else if (bready) m_wpend = 0;
      if (rd) m_rpend = 1; else if (rready) m_rpend = 0;
      wr_fire = wr; rd_fire = rd;
    end else begin
      wr_fire = 0; rd_fire = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output bit saw_b, output logic irq_hs);
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1; wvalid = 1; bready = 1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL wr_handshake_timeout addr=%h got_ready=0 required=1", addr);
    end
    tick();
    awvalid = 0; wvalid = 0;
    irq_hs = irq_out;
    saw_b = bvalid;
    tick();
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [31:0] exp);
    int n;
    araddr = addr; arvalid = 1; rready = 0;
    #1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL rd_handshake_timeout addr=%h got_ready=0 required=1", addr);
    end
    tick();
    arvalid = 0;
    data = rdata;
    exp = m_rdata;
    rready = 1;
    tick();
    rready = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    m_reset();
    #3;
    checks++;
    if (arready !== 1'b1 || awready !== 1'b0 || bvalid !== 1'b0 || rvalid !== 1'b0 ||
        irq_out !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got ar=%b aw=%b b=%b r=%b irq=%b rdata=%h required ar=1 others=0",
               arready, awready, bvalid, rvalid, irq_out, rdata);
    end
    @(posedge CLK); #1;
    RSTb = 1;
    for (int i = 0; i < 4; i++) begin
      axi_read(32'(i * 4), d, e);
      checks++;
      if (d !== 32'h0 || d !== e) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h required=00000000", i, d);
      end
      $display("read  addr=%h data=%h", 32'(i * 4), d);
    end
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b required=0", irq_out);
    end
  endtask

  task automatic test_debounce();
    bit sb; logic ih; logic [31:0] d, e;
    axi_write(32'hC, 32'h4, 4'hF, sb, ih);
    gpi[2] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (irq_out !== (k == 7) || irq_out !== m_irq) begin
        failures++;
        $display("FAIL debounce_latency edge=%0d irq got=%b required=%b", k, irq_out, (k == 7));
      end
    end
    axi_read(32'h0, d, e);
    checks++;
    if (d !== 32'h4 || d !== e) begin
      failures++; $display("FAIL debounce_state got=%h required=00000004", d);
    end
    axi_read(32'h4, d, e);
    checks++;
    if (d !== 32'h4 || d !== e) begin
      failures++; $display("FAIL debounce_press got=%h required=00000004", d);
    end
    $display("press gpi2 state/press=%h", d);
    gpi[2] = 1'b1;
    repeat (3) tick();
    gpi[2] = 1'b0;
    repeat (8) tick();
    axi_read(32'h0, d, e);
    checks++;
    if (d !== 32'h4 || d !== e) begin
      failures++; $display("FAIL glitch_state got=%h required=00000004", d);
    end
    axi_read(32'h8, d, e);
    checks++;
    if (d !== 32'h0 || d !== e) begin
      failures++; $display("FAIL glitch_release got=%h required=00000000", d);
    end
    $display("glitch release=%h", d);
    axi_write(32'hC, 32'h0, 4'hF, sb, ih);
  endtask

  task automatic test_irq();
    bit sb; logic ih; logic [31:0] d, e;
    axi_write(32'hC, 32'h4, 4'h1, sb, ih);
    checks++;
    if (ih !== 1'b0 || irq_out !== 1'b1) begin
      failures++; $display("FAIL irq_enable got=%b/%b required=0/1", ih, irq_out);
    end
    axi_write(32'h4, 32'h4, 4'h1, sb, ih);
    checks++;
    if (ih !== 1'b1 || irq_out !== 1'b0) begin
      failures++; $display("FAIL irq_clear got=%b/%b required=1/0", ih, irq_out);
    end
    axi_read(32'h4, d, e);
    checks++;
    if (d !== 32'h0 || d !== e) begin
      failures++; $display("FAIL irq_press_cleared got=%h required=00000000", d);
    end
    $display("irq w1c press=%h irq=%b", d, irq_out);
  endtask

  task automatic test_w1c_collision();
    bit sb; logic ih; logic [31:0] d, e;
    gpi[2] = 1'b1;
    repeat (8) tick();
    axi_write(32'h4, 32'h3F, 4'h1, sb, ih);
    gpi[2] = 1'b0;
    repeat (5) tick();
    axi_write(32'h4, 32'h4, 4'h1, sb, ih);
    axi_read(32'h4, d, e);
    checks++;
    if (d !== 32'h4 || d !== e) begin
      failures++; $display("FAIL w1c_collision got=%h required=00000004", d);
    end
    $display("collision press=%h", d);
  endtask

  task automatic test_handshake();
    bit sb; logic ih; logic [31:0] d, e, d0;
    awaddr = 32'hC; wdata = 32'h24; wstrb = 4'hF; bready = 0;
    awvalid = 1; wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (awready !== 1'b0 || wready !== 1'b0) begin
        failures++; $display("FAIL aw_only_ready got=%b/%b required=0/0", awready, wready);
      end
      tick();
    end
    wvalid = 1;
    #1;
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      failures++; $display("FAIL aw_w_ready got=%b/%b required=1/1", awready, wready);
    end
    tick();
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1) begin
        failures++; $display("FAIL bvalid_hold cycle=%0d got=%b required=1", i, bvalid);
      end
      tick();
    end
    bready = 1;
    tick();
    checks++;
    if (bvalid !== 1'b0) begin
      failures++; $display("FAIL bvalid_drop got=%b required=0", bvalid);
    end
    axi_read(32'hC, d, e);
    checks++;
    if (d !== 32'h24 || d !== e) begin
      failures++; $display("FAIL irq_en_readback got=%h required=00000024", d);
    end
    axi_write(32'hC, 32'h3B, 4'h0, sb, ih);
    checks++;
    if (sb !== 1'b1) begin
      failures++; $display("FAIL wstrb0_bvalid got=%b required=1", sb);
    end
    axi_read(32'hC, d, e);
    checks++;
    if (d !== 32'h24 || d !== e) begin
      failures++; $display("FAIL wstrb0_unchanged got=%h required=00000024", d);
    end
    araddr = 32'h8; arvalid = 1; rready = 0;
    tick();
    arvalid = 0;
    d0 = rdata;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== d0 || rdata !== m_rdata || arready !== 1'b0) begin
        failures++;
        $display("FAIL rvalid_hold cycle=%0d got rv=%b data=%h required rv=1 data=%h",
                 i, rvalid, rdata, m_rdata);
      end
      tick();
    end
    rready = 1;
    tick();
    rready = 0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++; $display("FAIL rvalid_drop got rv=%b ar=%b required rv=0 ar=1", rvalid, arready);
    end
    $display("handshake stress release=%h", d0);
  endtask

  task automatic test_random();
    bit wr_act, rd_act;
    int nrd;
    wr_act = 0; rd_act = 0; nrd = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) gpi[$urandom_range(0, NB - 1)] ^= 1'b1;
      if (!wr_act && !m_wpend && $urandom_range(0, 3) == 0) begin
        wr_act = 1;
        awaddr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
      end
      if (wr_act) begin
        if (!awvalid && $urandom_range(0, 1) == 1) awvalid = 1;
        if (!wvalid && $urandom_range(0, 1) == 1) wvalid = 1;
      end
      bready = 1'($urandom_range(0, 1));
      if (!rd_act && !m_rpend && $urandom_range(0, 2) == 0) begin
        rd_act = 1; araddr = $urandom; arvalid = 1;
      end
      rready = 1'($urandom_range(0, 1));
      tick();
      if (wr_fire) begin awvalid = 0; wvalid = 0; wr_act = 0; end
      if (rd_fire) begin arvalid = 0; rd_act = 0; nrd++; end
      checks++;
      if (bvalid !== m_wpend || rvalid !== m_rpend || arready !== !m_rpend || irq_out !== m_irq) begin
        failures++;
        $display("FAIL random_ctrl cycle=%0d got b=%b r=%b ar=%b irq=%b required b=%b r=%b ar=%b irq=%b",
                 c, bvalid, rvalid, arready, irq_out, m_wpend, m_rpend, !m_rpend, m_irq);
      end
      if (m_rpend) begin
        checks++;
        if (rdata !== m_rdata) begin
          failures++;
          $display("FAIL random_rdata cycle=%0d got=%h required=%h", c, rdata, m_rdata);
        end
      end
    end
    $display("random done reads=%0d", nrd);
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    repeat (3) tick();
    bready = 0; rready = 0;
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d, e;
    gpi = '1;
    araddr = 32'h0; arvalid = 1; rready = 0;
    tick();
    arvalid = 0;
    checks++;
    if (rvalid !== 1'b1) begin
      failures++; $display("FAIL midread_rvalid got=%b required=1", rvalid);
    end
    #2 RSTb = 0;
    m_reset();
    #1;
    checks++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0 || irq_out !== 1'b0) begin
      failures++; $display("FAIL midread_reset_drop got rv=%b b=%b irq=%b required 0", rvalid, bvalid, irq_out);
    end
    tick();
    RSTb = 1;
    #1;
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      failures++; $display("FAIL midread_release got ar=%b rv=%b required ar=1 rv=0", arready, rvalid);
    end
    rready = 1;
    tick();
    rready = 0;
    checks++;
    if (rvalid !== 1'b0) begin
      failures++; $display("FAIL midread_no_completion got=%b required=0", rvalid);
    end
    axi_read(32'hC, d, e);
    checks++;
    if (d !== 32'h0 || d !== e) begin
      failures++; $display("FAIL midread_irq_en got=%h required=00000000", d);
    end
    $display("reset mid-read irq_en=%h", d);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_irq();
    test_w1c_collision();
    test_handshake();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpi_axil_ctrl.md
# gpi_axil_ctrl

AXI4-lite slave peripheral that debounces the six `gpi` button inputs and exposes their level, sticky press/release events and an interrupt mask as four 32-bit registers. It sits beside `memory_controller`, downstream of the CPU's AXI4-lite master through the address decoder, on the same AW/W/B/AR/R signal set. It drives a level interrupt into the CPU `irq` vector.

## Interface
- `NUM_BUTTONS`, 6: number of button inputs (1..8).
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles needed to accept a new level (≥2).
- `ACTIVE_LOW`, 1: 1 = `gpi` low means pressed; inputs are inverted before synchronisation.
- `CLK`  in  1  system clock; single clock domain.
- `RSTb`  in  1  reset, asynchronous assert, active-low.
- `gpi`  in  NUM_BUTTONS  raw asynchronous button pins.
- `s_axi_awvalid`/`s_axi_awready`  in/out  1  write-address handshake.
- `s_axi_awaddr`  in  32  write address; only bits [3:2] decoded.
- `s_axi_awprot`  in  3  ignored.
- `s_axi_wvalid`/`s_axi_wready`  in/out  1  write-data handshake.
- `s_axi_wdata`  in  32  write data.
- `s_axi_wstrb`  in  4  only bit 0 used.
- `s_axi_bvalid`/`s_axi_bready`  out/in  1  write response.
- `s_axi_arvalid`/`s_axi_arready`  in/out  1  read-address handshake.
- `s_axi_araddr`  in  32  read address; bits [3:2] decoded.
- `s_axi_arprot`  in  3  ignored.
- `s_axi_rvalid`/`s_axi_rready`  out/in  1  read-data handshake.
- `s_axi_rdata`  out  32  read data.
- `irq_out`  out  1  `|(PRESS & IRQ_EN)`, registered.

## Operation
- Registers (offset by addr[3:2]). Bits above NUM_BUTTONS read 0.
  - 0x0 STATE: debounced levels, 1 = pressed. RO; writes ignored.
  - 0x4 PRESS: sticky 0→1 events. W1C.
  - 0x8 RELEASE: sticky 1→0 events. W1C.
  - 0xC IRQ_EN: RW mask.
- Per bit: polarity stage, then 2-flop synchroniser, then counter.
  - While sync ≠ debounced, counter increments.
  - When sync = debounced, counter clears to 0.
  - On the count reaching DEBOUNCE_CYCLES−1 while sync still differs: debounced ← sync, counter ← 0, one-cycle press or release pulse.
- Write FSM, states W_IDLE and W_RESP:
  - `awready = wready = (W_IDLE & awvalid & wvalid)`, combinational.
  - The register update happens on that handshake edge, then go to W_RESP.
  - In W_RESP, `bvalid` = 1 until `bready`, then return to W_IDLE.
  - AW without W, or W without AW, waits and is not accepted.
- Read FSM, states R_IDLE and R_DATA:
  - `arready = R_IDLE`.
  - On handshake, `rdata` is captured and the FSM goes to R_DATA.
  - `rvalid` and `rdata` are held stable until `rready`.
- Write qualification: `wstrb[0]` = 0 → no register change, but the response is still issued.
- Simultaneous W1C and new event on the same bit: the event wins and the bit stays 1.
- A read of PRESS on the same edge as an event returns the pre-event value.
- Read and write channels are independent and may complete in the same cycle.

## Timing
- Reset values:
  - `awready`, `wready`, `bvalid`, `rvalid`, `irq_out`, `rdata` = 0; `arready` = 1.
  - Sync flops, debounced levels, counters, PRESS, RELEASE and IRQ_EN = 0.
- Reset asserted mid-transaction drops `bvalid`/`rvalid` immediately; the transaction is lost and no completion follows.
- Pin-to-STATE latency: a level held stable updates STATE 2 + DEBOUNCE_CYCLES edges after first sampling. The PRESS/RELEASE bit sets on the same edge.
- `irq_out` follows PRESS/IRQ_EN by one cycle.
- Write: handshake at edge N → `bvalid` high after N, register visible from N.
- Read: handshake at edge N → `rvalid` high after N. Next `arready` comes the cycle after `rready` is accepted.
- Glitch shorter than DEBOUNCE_CYCLES after sync → no STATE change, no event.

## Structure
- `slurmboy_pkg`: register offset constants (`GPI_REG_STATE` … `GPI_REG_IRQ_EN`) and the FSM state encodings.
- Sub-module `gpi_debounce`: one bit of synchroniser, counter, debounced level and press/release pulses, instanced NUM_BUTTONS times in a generate loop.
- The top contains the AXI FSMs and the register file.

## Test plan
Benches run with DEBOUNCE_CYCLES = 4 and ACTIVE_LOW = 1.
- Reset: read 0x0, 0x4, 0x8, 0xC → all 0x00000000; `irq_out` = 0.
- Debounce: drive `gpi[2]` low and hold → STATE = 0x04 and PRESS = 0x04 exactly 6 edges later. Then a 3-cycle glitch high on `gpi[2]` → STATE unchanged, RELEASE = 0.
- IRQ:
  - Write IRQ_EN = 0x04 with PRESS = 0x04 → `irq_out` = 1 one cycle after the write.
  - Write 0x04 to 0x4 → PRESS = 0, `irq_out` = 0 next cycle.
- W1C collision: a W1C of bit 2 on the same edge as a new press event on bit 2 → PRESS reads 0x04.
- Handshake stress:
  - AW valid 3 cycles before W → no ready until both are valid.
  - Hold `bready`/`rready` low 5 cycles → `bvalid`/`rvalid`/`rdata` stable.
  - `wstrb` = 0 write to IRQ_EN → value unchanged, `bvalid` still issued.
- Reset mid-read: assert `RSTb` low while `rvalid` = 1 → `rvalid` = 0 immediately, `arready` = 1 after release.
